// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op/state encodings and widths for the load/store unit
package lsu_pkg;
    localparam int DATA_W = 32;
    localparam int OFF_W  = 2;

    typedef enum logic [2:0] {
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE, S_READ, S_WRITE, S_RESP
    } state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: big-endian load extraction and sub-word store merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  offset,
    input  op_t               op,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mdata
);
    logic [OFF_W+2:0] sh;
    logic [7:0]       b;
    logic [15:0]      h;

    // offset 0 is the most significant byte
    assign sh = {~offset, 3'b000};
    assign b  = 8'(word >> sh);
    assign h  = offset[1] ? word[15:0] : word[31:16];

    always_comb begin
        rdata = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : word;
        mdata = op == OP_SB ? (word & ~(32'hFF << sh)) | ({24'b0, wdata[7:0]} << sh) :
                op == OP_SH ? (offset[1] ? {word[31:16], wdata[15:0]} : {wdata[15:0], word[15:0]}) :
                wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-request memory stage with byte/half/word access over a word port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEMORY_SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            state;
    op_t               op_q;
    op_t               op_in;
    logic [DATA_W-1:0] addr_q, wdata_q, word_q, ext, merged;
    logic              fault_q, fault;

    assign op_in = op_t'(req_op);

    always_comb begin
        fault = ((op_in == OP_LH || op_in == OP_LHU || op_in == OP_SH) && req_addr[0]) ||
                ((op_in == OP_LW || op_in == OP_SW) && req_addr[1:0] != 2'b00) ||
                ({req_addr[31:2], 2'b00} > 32'(MEMORY_SIZE - 4));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q    <= op_in;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    fault_q <= fault;
                    state   <= fault ? S_RESP : op_in == OP_SW ? S_WRITE : S_READ;
                end
                S_READ: begin
                    word_q <= mem_rdata;
                    state  <= (op_q == OP_SB || op_q == OP_SH) ? S_WRITE : S_RESP;
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

    lsu_align u_align (
        .word  (word_q),
        .offset(addr_q[1:0]),
        .op    (op_q),
        .wdata (wdata_q),
        .rdata (ext),
        .mdata (merged)
    );

    assign req_ready  = state == S_IDLE;
    assign resp_valid = state == S_RESP;
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = (resp_valid && !fault_q && !(op_q inside {OP_SB, OP_SH, OP_SW})) ? ext : '0;
    assign mem_write  = state == S_WRITE;
    assign mem_addr   = (state == S_READ || mem_write) ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata  = mem_write ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, cycle-level corner sequences and random traffic
module tb_load_store_unit;
    localparam logic [2:0] LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7;
    localparam int MEM = 16;

    logic        clk = 0, rst = 0, req_valid = 0;
    logic [2:0]  req_op = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_fault, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEMORY_SIZE(MEM)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    logic [7:0] dmem [MEM];
    logic [7:0] ref_mem [MEM];
    logic       do_init = 0;

    function automatic logic [7:0] init_byte(int i);
        return i == 8 ? 8'h88 : i == 9 ? 8'h99 : i == 10 ? 8'hAA : i == 11 ? 8'hBB : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (do_init)
            for (int i = 0; i < MEM; i++) dmem[i] <= init_byte(i);
        else if (mem_write)
            for (int i = 0; i < 4; i++) dmem[{mem_addr[3:2], 2'(i)}] <= mem_wdata[31-8*i -: 8];
    end

    assign mem_rdata = {dmem[{mem_addr[3:2], 2'd0}], dmem[{mem_addr[3:2], 2'd1}],
                        dmem[{mem_addr[3:2], 2'd2}], dmem[{mem_addr[3:2], 2'd3}]};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic init_mem();
        do_init = 1;
        for (int i = 0; i < MEM; i++) ref_mem[i] = init_byte(i);
        @(posedge clk);
        #1 do_init = 0;
    endtask

    // byte-addressed reference: sizes, alignment and range straight from the access rules
    task automatic ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                            output logic [31:0] r, output logic f, output int lat, output int wr);
        int sz;
        longint v;
        sz = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
        f = (a % sz != 0) || ((a - a % 4) > MEM - 4);
        r = 0;
        wr = 0;
        lat = f ? 1 : (op == SB || op == SH) ? 3 : 2;
        if (!f && op < SB) begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v * 256 + ref_mem[int'(a[3:0]) + i];
            if ((op == LB || op == LH) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
            r = v[31:0];
        end
        if (!f && op >= SB) begin
            wr = 1;
            for (int i = 0; i < sz; i++) ref_mem[int'(a[3:0]) + i] = 8'(w >> (8 * (sz - 1 - i)));
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] er, input logic ef, input int el, input int ewr, input string nm);
        int lat, nwr;
        logic leak;
        @(negedge clk);
        for (int k = 0; k < 8 && !req_ready; k++) @(negedge clk);
        chk({nm, "_ready"}, req_ready, 1);
        req_valid = 1; req_op = op; req_addr = a; req_wdata = w;
        @(negedge clk);
        req_valid = 0;
        lat = 1; nwr = 0; leak = 0;
        while (!resp_valid && lat < 6) begin
            nwr += int'(mem_write);
            leak |= mem_addr != 0;
            @(negedge clk);
            lat++;
        end
        nwr += int'(mem_write);
        leak |= mem_addr != 0;
        chk({nm, "_valid"}, resp_valid, 1);
        chk({nm, "_latency"}, lat, el);
        chk({nm, "_rdata"}, resp_rdata, er);
        chk({nm, "_fault"}, resp_fault, ef);
        chk({nm, "_writes"}, nwr, ewr);
        if (ef) chk({nm, "_addr_leak"}, leak, 0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wdata, rdata;
        logic        fault;
        int          lat, wr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [2:0]  op;
        logic [31:0] a, w, er;
        logic        ef, pulsed;
        int          el, ewr;

        tbl.push_back('{LW,  32'd8,  32'h0,        32'h8899AABB, 1'b0, 2, 0});
        tbl.push_back('{LB,  32'd9,  32'h0,        32'hFFFFFF99, 1'b0, 2, 0});
        tbl.push_back('{LBU, 32'd9,  32'h0,        32'h00000099, 1'b0, 2, 0});
        tbl.push_back('{LH,  32'd10, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0});
        tbl.push_back('{LHU, 32'd8,  32'h0,        32'h00008899, 1'b0, 2, 0});
        tbl.push_back('{LW,  32'd6,  32'h0,        32'h0,        1'b1, 1, 0});
        tbl.push_back('{SH,  32'd9,  32'h5555,     32'h0,        1'b1, 1, 0});
        tbl.push_back('{LW,  32'd16, 32'h0,        32'h0,        1'b1, 1, 0});
        tbl.push_back('{LW,  32'hFFFFFFFC, 32'h0,  32'h0,        1'b1, 1, 0});
        tbl.push_back('{LB,  32'd16, 32'h0,        32'h0,        1'b1, 1, 0});
        tbl.push_back('{LHU, 32'd11, 32'h0,        32'h0,        1'b1, 1, 0});
        tbl.push_back('{SB,  32'd10, 32'h12345677, 32'h0,        1'b0, 3, 1});
        tbl.push_back('{LW,  32'd8,  32'h0,        32'h889977BB, 1'b0, 2, 0});
        tbl.push_back('{SW,  32'd0,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1});
        tbl.push_back('{LH,  32'd2,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 0});
        tbl.push_back('{LBU, 32'd1,  32'h0,        32'h000000AD, 1'b0, 2, 0});
        tbl.push_back('{SH,  32'd14, 32'h1234CAFE, 32'h0,        1'b0, 3, 1});
        tbl.push_back('{LW,  32'd12, 32'h0,        32'h0000CAFE, 1'b0, 2, 0});
        tbl.push_back('{LB,  32'd15, 32'h0,        32'hFFFFFFFE, 1'b0, 2, 0});
        tbl.push_back('{SW,  32'd13, 32'h1,        32'h0,        1'b1, 1, 0});

        init_mem();
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1;

        foreach (tbl[i])
            run(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].fault,
                tbl[i].lat, tbl[i].wr, $sformatf("vec%0d", i));

        // SB read-modify-write, cycle by cycle
        @(negedge clk);
        init_mem();
        @(negedge clk);
        req_valid = 1; req_op = SB; req_addr = 10; req_wdata = 32'h12345677;
        @(negedge clk);
        req_valid = 0;
        chk("sb_t1_addr", mem_addr, 8);
        chk("sb_t1_write", mem_write, 0);
        chk("sb_t1_valid", resp_valid, 0);
        @(negedge clk);
        chk("sb_t2_write", mem_write, 1);
        chk("sb_t2_addr", mem_addr, 8);
        chk("sb_t2_wdata", mem_wdata, 32'h889977BB);
        @(negedge clk);
        chk("sb_t3_valid", resp_valid, 1);
        chk("sb_t3_write", mem_write, 0);
        chk("sb_t3_rdata", resp_rdata, 0);
        chk("sb_mem_byte", dmem[10], 8'h77);

        // back-to-back with req_valid held high
        @(negedge clk);
        init_mem();
        @(negedge clk);
        req_valid = 1; req_op = LW; req_addr = 8;
        @(negedge clk);
        chk("b2b_t1_ready", req_ready, 0);
        chk("b2b_t1_addr", mem_addr, 8);
        req_op = LBU; req_addr = 9;
        @(negedge clk);
        chk("b2b_t2_ready", req_ready, 0);
        chk("b2b_t2_valid", resp_valid, 1);
        chk("b2b_t2_rdata", resp_rdata, 32'h8899AABB);
        @(negedge clk);
        chk("b2b_t3_ready", req_ready, 1);
        chk("b2b_t3_valid", resp_valid, 0);
        @(negedge clk);
        req_valid = 0;
        chk("b2b_t4_ready", req_ready, 0);
        chk("b2b_t4_addr", mem_addr, 8);
        @(negedge clk);
        chk("b2b_t5_valid", resp_valid, 1);
        chk("b2b_t5_rdata", resp_rdata, 32'h00000099);

        // reset during the WRITE cycle of an SH
        @(negedge clk);
        req_valid = 1; req_op = SH; req_addr = 8; req_wdata = 32'h1111;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("rstw_write_before", mem_write, 1);
        rst = 0;
        #1;
        chk("rstw_write_drop", mem_write, 0);
        chk("rstw_addr_drop", mem_addr, 0);
        chk("rstw_ready", req_ready, 1);
        pulsed = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pulsed |= resp_valid;
        end
        rst = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulsed |= resp_valid;
        end
        chk("rstw_no_resp", pulsed, 0);
        chk("rstw_ready_after", req_ready, 1);
        chk("rstw_mem_intact", {dmem[8], dmem[9]}, 16'h8899);

        // random traffic against the byte-level reference
        init_mem();
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 9) < 9 ? 32'($urandom_range(0, 19)) : $urandom;
            w = $urandom;
            ref_calc(op, a, w, er, ef, el, ewr);
            run(op, a, w, er, ef, el, ewr, $sformatf("rnd%0d", n));
        end
        @(negedge clk);
        for (int i = 0; i < MEM; i++) chk($sformatf("rnd_mem%0d", i), dmem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", checks);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the execute stage and the word-wide, big-endian data memory. It accepts one load or store request at a time and performs byte, halfword and word accesses over a word-only memory port. Sub-word stores use a read-modify-write sequence. Misaligned and out-of-range accesses are reported as faults and never reach memory.

## Interface
- MEMORY_SIZE, 16: data memory size in bytes; the valid word-aligned range is 0..MEMORY_SIZE-4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or low halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid; misaligned or out-of-range access.
- mem_addr  out  32  word-aligned address, {addr_q[31:2],2'b00}; 0 outside READ/WRITE.
- mem_wdata  out  32  write word; 0 outside WRITE.
- mem_write  out  1  write strobe; high only in WRITE.
- mem_rdata  in  32  combinational read word for mem_addr; big-endian (offset 0 = bits [31:24]).

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request capture:
  - req_ready = (state == IDLE).
  - On req_valid & req_ready, latch op, addr and wdata.
- Fault check on the captured request:
  - LH/LHU/SH with addr[0] = 1 is misaligned.
  - LW/SW with addr[1:0] != 0 is misaligned.
  - A word address {addr[31:2],2'b00} > MEMORY_SIZE-4 is out of range. Compare at full 32-bit width.
- Transitions out of IDLE on accept:
  - fault: go to RESP.
  - SW: go to WRITE.
  - any other op: go to READ.
- READ: register mem_rdata. Loads then go to RESP; SB/SH go to WRITE.
- WRITE:
  - SW writes wdata.
  - SB replaces byte k = addr[1:0] of the read word (bits [31-8k -: 8]) with wdata[7:0].
  - SH replaces bits [31:16] (addr[1] = 0) or [15:0] (addr[1] = 1) with wdata[15:0].
  - Then go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then return to IDLE. There is no response backpressure.
- Load extraction from the READ word:
  - Byte k: bits [31-8k -: 8].
  - Half: bits [31:16] or [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Reset values: state IDLE, all registers 0, req_ready = 1, resp_valid = 0, resp_fault = 0, resp_rdata = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Reset mid-operation: return to IDLE immediately (asynchronously).
  - mem_write drops in the same cycle reset is asserted.
  - No response is issued for the aborted request.
  - A partially executed read-modify-write is abandoned, never completed.

## Timing
- Request accepted at edge T (end of the IDLE cycle):
  - LB/LBU/LH/LHU/LW: READ in cycle T+1, resp_valid in T+2.
  - SW: WRITE in T+1, resp_valid in T+2.
  - SB/SH: READ in T+1, WRITE in T+2, resp_valid in T+3.
  - Fault: resp_valid in T+1; no READ or WRITE cycle.
- Next accept is possible in the cycle after RESP. Minimum request spacing is 3 cycles (2 for faults).
- All mem_* and resp_* outputs decode from registered state and data only; there is no combinational path from req_* to any output except through req_ready's dependence on state.
- mem_rdata is sampled only at the edge ending READ.

## Structure
- lsu_pkg holds:
  - the op encoding enum (3 bits);
  - the state enum;
  - width constants (32 data bits, 2 offset bits).
- lsu_align is a combinational sub-module containing both data functions:
  - extract: word, offset, op -> load result;
  - merge: word, offset, op, wdata -> store word.
- load_store_unit holds the FSM, the request registers, the read-word register and the fault logic.

## Test plan
- Memory model: bytes 8..11 = 88 99 AA BB, MEMORY_SIZE = 16.
- LW at 8, accepted at T: READ with mem_addr = 8 in T+1; resp_valid in T+2 with rdata 0x8899AABB and fault 0.
- Sub-word loads:
  - LB at 9 gives 0xFFFFFF99.
  - LBU at 9 gives 0x00000099.
  - LH at 10 gives 0xFFFFAABB.
  - LHU at 8 gives 0x00008899.
- SB at 10 with wdata 0x12345677: READ at 8 in T+1; WRITE in T+2 with mem_wdata 0x889977BB and mem_write = 1; resp_valid in T+3.
- Faults:
  - LW at 6 gives resp_valid with fault 1 in T+1.
  - SH at 9 gives a fault.
  - LW at 16 gives a fault.
  - In all cases mem_write stays 0 and mem_addr stays 0.
- Back-to-back: hold req_valid high with two requests; req_ready is low from T+1 until after RESP, and the second request is accepted exactly in the first IDLE cycle.
- Reset: assert rst low during the WRITE cycle of an SH. mem_write falls in the same cycle, resp_valid never pulses, and req_ready = 1 after release.
